// File: rtl/ws2812_pkg.sv
// ws2812_pkg
// Shared definitions for the WS2812 frame scheduler: the scheduler state
// encoding, the per-LED bit count and the default timing constants for a
// 125 MHz clock. Also provides a small helper that sizes counters.
package ws2812_pkg;

  // Bits per LED in GRB order.
  localparam int unsigned LED_BITS = 24;

  // Defaults for a 125 MHz clock.
  localparam int unsigned DEF_FRAME_CYCLES   = 2_083_333;  // 60 Hz frame rate
  localparam int unsigned DEF_LATCH_CYCLES   = 37_500;     // 300 us reset gap
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;  // chain_done watchdog

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Width of a counter that must hold the values 0 .. n-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ws2812_rr_arb2.sv
// ws2812_rr_arb2
// Two-way round-robin arbiter. Grants are combinational and only issued
// while en is high. A lone requester always wins; when both request, the
// side holding priority wins and priority then passes to the other side.
// Priority starts on side b after reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                arbitration window (a grant may be issued this cycle)
//   req_a, req_b      request levels
//   grant_a, grant_b  one-hot grant for the current cycle
module ws2812_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  logic prio_b;  // 1: b wins a tie, 0: a wins a tie

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      grant_b = req_b & (prio_b | ~req_a);
      grant_a = req_a & (~prio_b | ~req_b);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst)          prio_b <= 1'b1;
    else if (grant_a) prio_b <= 1'b1;
    else if (grant_b) prio_b <= 1'b0;
  end

endmodule

// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched
// Frame scheduler for a WS2812 LED chain. A free-running frame timer raises
// a pending flag once per frame period; when the scheduler is idle and a
// frame is pending, one of two requesters is granted (round-robin on a tie),
// its frame is captured into chain_data and the chain driver is started.
// After the driver reports completion (or a watchdog expires) the scheduler
// holds a latch gap before accepting the next frame.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_a, req_b       frame requests, held until granted
//   data_a, data_b     GRB frame data, valid while the matching req is high
//   grant_a, grant_b   one-cycle grant pulses
//   chain_start        one-cycle start pulse to the chain driver
//   chain_data         registered frame shadow for the chain driver
//   chain_done         one-cycle completion pulse from the chain driver
//   busy               scheduler not idle
//   err                sticky watchdog flag, cleared only by rst
//   frame_cnt          frames completed (wraps)
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 16,
  parameter int unsigned FRAME_CYCLES   = DEF_FRAME_CYCLES,
  parameter int unsigned LATCH_CYCLES   = DEF_LATCH_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES  // must be >= 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_a,
  input  logic                         req_b,
  input  logic [NUM_LEDS*LED_BITS-1:0] data_a,
  input  logic [NUM_LEDS*LED_BITS-1:0] data_b,
  output logic                         grant_a,
  output logic                         grant_b,
  output logic                         chain_start,
  output logic [NUM_LEDS*LED_BITS-1:0] chain_data,
  input  logic                         chain_done,
  output logic                         busy,
  output logic                         err,
  output logic [15:0]                  frame_cnt
);

  localparam int unsigned TW        = cnt_width(FRAME_CYCLES);
  localparam int unsigned DWELL_MAX = (TIMEOUT_CYCLES > LATCH_CYCLES) ?
                                      TIMEOUT_CYCLES : LATCH_CYCLES;
  localparam int unsigned CW        = cnt_width(DWELL_MAX);

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [CW-1:0] dwell;       // cycles spent in the current state
  logic          wrap;
  logic          pending;
  logic          pend_eff;
  logic          arb_en;
  logic          grant_any;
  logic          wd_expired;
  logic          latch_over;

  // ---------------------------------------------------------------- timer
  assign wrap = (timer == TW'(FRAME_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || wrap) timer <= '0;
    else             timer <= timer + TW'(1);
  end

  // A wrap in the current cycle is as good as a stored pending flag, so the
  // frame can be granted on the wrap cycle itself.
  assign pend_eff = pending | wrap;

  // A grant consumes one pending token. If a stored token and a fresh wrap
  // coincide with the grant, one token survives for the next frame.
  always_ff @(posedge clk) begin
    if (rst)            pending <= 1'b0;
    else if (grant_any) pending <= pending & wrap;
    else                pending <= pend_eff;
  end

  // ---------------------------------------------------------------- arbiter
  assign arb_en = (state == ST_IDLE) & pend_eff & ~rst;

  ws2812_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req_a   (req_a),
    .req_b   (req_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign grant_any = grant_a | grant_b;

  // ---------------------------------------------------------------- dwell
  always_ff @(posedge clk) begin
    if (rst || (state_next != state)) dwell <= '0;
    else                              dwell <= dwell + CW'(1);
  end

  // The chain_start (LOAD) cycle counts toward the watchdog, so the expiry
  // lands TIMEOUT_CYCLES-1 cycles after chain_start and err rises exactly
  // TIMEOUT_CYCLES cycles after it.
  assign wd_expired = (state == ST_SEND) && (dwell == CW'(TIMEOUT_CYCLES - 2));
  assign latch_over = (state == ST_LATCH) && (dwell == CW'(LATCH_CYCLES - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (grant_any) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SEND;
      ST_SEND:  if (chain_done || wd_expired) state_next = ST_LATCH;
      ST_LATCH: if (latch_over) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    chain_start = (state == ST_LOAD);
    busy        = (state != ST_IDLE);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst)          chain_data <= '0;
    else if (grant_a) chain_data <= data_a;
    else if (grant_b) chain_data <= data_b;
  end

  // chain_done wins over a simultaneous watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst)                                   frame_cnt <= '0;
    else if ((state == ST_SEND) && chain_done) frame_cnt <= frame_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)                           err <= 1'b0;
    else if (wd_expired && !chain_done) err <= 1'b1;
  end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
module tb_ws2812_frame_sched;

  localparam int F  = 100;
  localparam int L  = 10;
  localparam int T  = 500;
  localparam int N  = 2;
  localparam int DW = N * 24;
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b;
  logic [DW-1:0] data_a, data_b;
  logic          grant_a, grant_b;
  logic          chain_start;
  logic [DW-1:0] chain_data;
  logic          chain_done;
  logic          busy, err;
  logic [15:0]   frame_cnt;

  ws2812_frame_sched #(
    .NUM_LEDS(N), .FRAME_CYCLES(F), .LATCH_CYCLES(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .grant_a(grant_a), .grant_b(grant_b),
    .chain_start(chain_start), .chain_data(chain_data), .chain_done(chain_done),
    .busy(busy), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ stimulus state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_at    = -1;   // absolute cycle at which the driver reports done
  int done_delay = -1;   // >=1 fixed, -1 never, -2 random
  bit noise_en   = 0;    // spurious chain_done pulses
  int gcount     = 0;    // grants since last reset
  int gq[$];             // grant winners since last reset: 0=a 1=b

  // Chain driver stand-in.
  initial begin
    chain_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      chain_done = (cyc == done_at) || (noise_en && ($urandom_range(0, 29) == 0));
    end
  end

  // ------------------------------------------------------------ reference model
  // Frame lifecycle tracked by timestamps: grant at m_g, chain_start at m_g+1,
  // completion window m_g+2 .. m_g+T, idle again at m_idle_at.
  bit          m_live = 0;
  int          m_t, m_g, m_idle_at;
  bit          m_pend, m_prefer_b, m_open, m_err;
  logic [DW-1:0] m_data;
  logic [15:0] m_fcnt;

  always @(negedge clk) begin
    bit idle, wrap, win_a, win_b;
    if (rst) begin
      if (m_live) begin
        check("grant_a_in_rst", grant_a, 0);
        check("grant_b_in_rst", grant_b, 0);
      end
      m_live = 1; m_t = 0; m_g = -10; m_idle_at = 0;
      m_pend = 0; m_prefer_b = 1; m_open = 0; m_err = 0;
      m_data = '0; m_fcnt = '0;
    end else if (m_live) begin
      idle  = (m_t >= m_idle_at);
      wrap  = ((m_t % F) == F - 1);
      win_a = 0; win_b = 0;
      if (idle && (m_pend || wrap)) begin
        if (req_a && req_b) begin win_b = m_prefer_b; win_a = !m_prefer_b; end
        else begin win_a = req_a; win_b = req_b; end
      end
      check("grant_a", grant_a, win_a);
      check("grant_b", grant_b, win_b);
      check("chain_start", chain_start, (m_t == m_g + 1));
      check("busy", busy, !idle);
      check("chain_data", chain_data, m_data);
      check("err", err, m_err);
      check("frame_cnt", frame_cnt, m_fcnt);

      if (m_open && m_t >= m_g + 2) begin
        if (chain_done) begin
          m_fcnt = m_fcnt + 16'd1; m_open = 0; m_idle_at = m_t + 1 + L;
        end else if (m_t == m_g + T) begin
          m_err = 1; m_open = 0; m_idle_at = m_t + 1 + L;
        end
      end
      if (win_a || win_b) begin
        m_data = win_a ? data_a : data_b;
        m_g = m_t; m_open = 1; m_idle_at = NEVER;
        m_prefer_b = win_a;
        m_pend = m_pend && wrap;
      end else begin
        m_pend = m_pend || wrap;
      end
      m_t++;
    end

    // bookkeeping for stimulus and directed checks
    if (!rst) begin
      if (grant_a || grant_b) begin
        gcount++;
        gq.push_back(grant_b ? 1 : 0);
      end
      if (chain_start) begin
        if (done_delay > 0) done_at = cyc + done_delay;
        else if (done_delay == -2)
          done_at = ($urandom_range(0, 9) == 0) ? -1 : cyc + $urandom_range(1, 60);
      end
    end
  end

  // ------------------------------------------------------------ sequencing
  int tt;  // cycles since last reset release

  task automatic do_reset();
    rst = 1; req_a = 0; req_b = 0; done_at = -1;
    @(posedge clk); #1;
    rst = 0; tt = 0; gcount = 0; gq.delete();
  endtask

  task automatic goto(input int k);
    while (tt < k) begin
      @(posedge clk); #1;
      tt++;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; req_a = 0; req_b = 0; data_a = '0; data_b = '0;
    @(posedge clk); #1;

    // --- single requester, normal frame
    do_reset();
    goto(0);
    check("rst_busy", busy, 0);
    check("rst_chain_data", chain_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_chain_start", chain_start, 0);
    data_a = 48'h00FF00_FF0000; req_a = 1; done_delay = 20;
    goto(98);  check("s1_no_grant_t98", grant_a, 0);
    goto(99);  check("s1_grant_a_t99", grant_a, 1);
               check("s1_chain_data_t99", chain_data, 0);
    goto(100); check("s1_start_t100", chain_start, 1);
               check("s1_data_t100", chain_data, 48'h00FF00_FF0000);
    req_a = 0;
    goto(101); check("s1_start_t101", chain_start, 0);
    goto(121); check("s1_frame_cnt", frame_cnt, 1);
    goto(124); done_at = cyc + 1;  // stray done during LATCH
    goto(130); check("s1_busy_t130", busy, 1);
    goto(131); check("s1_busy_t131", busy, 0);
    goto(159); done_at = cyc + 1;  // stray done during IDLE
    goto(170); check("s1_frame_cnt_stray", frame_cnt, 1);
               check("s1_busy_stray", busy, 0);

    // --- both requesters: b, a, b
    do_reset();
    data_a = 48'hAAAAAA_AAAAAA; data_b = 48'hBBBBBB_BBBBBB;
    req_a = 1; req_b = 1; done_delay = 20;
    goto(320);
    check("s2_grants", gq.size(), 3);
    if (gq.size() >= 3) begin
      check("s2_first_b", gq[0], 1);
      check("s2_second_a", gq[1], 0);
      check("s2_third_b", gq[2], 1);
    end

    // --- watchdog
    do_reset();
    req_a = 1; done_delay = -1;
    goto(100); req_a = 0;
    goto(599); check("s3_err_t599", err, 0);
    goto(600); check("s3_err_t600", err, 1);
               check("s3_frame_cnt", frame_cnt, 0);
    goto(609); check("s3_busy_t609", busy, 1);
    goto(610); check("s3_busy_t610", busy, 0);
    goto(700); check("s3_err_sticky", err, 1);

    // --- late request served on first high cycle
    do_reset();
    done_delay = 20;
    goto(150); req_a = 1; #1;
    check("s4_grant_t150", grant_a, 1);
    goto(198); check("s4_one_grant", gcount, 1);
    goto(199); check("s4_grant_t199", grant_a, 1);

    // --- wrap coinciding with grant keeps pending
    do_reset();
    req_a = 1; done_delay = 188;
    goto(299); check("s5_grant_t299", grant_a, 1);
    goto(499); check("s5_grant_t499", grant_a, 1);
    goto(520);

    // --- reset in the middle of SEND
    do_reset();
    data_a = 48'h123456_789ABC; req_a = 1; done_delay = 20;
    goto(105);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; tt = 0; gcount = 0;
    #1;
    check("s6_busy", busy, 0);
    check("s6_chain_data", chain_data, 0);
    check("s6_chain_start", chain_start, 0);
    goto(30);  check("s6_frame_cnt", frame_cnt, 0);
    goto(98);  check("s6_no_grant", gcount, 0);
    goto(99);  check("s6_grant_t99", grant_a, 1);
    goto(130);

    // --- randomized traffic with stray chain_done pulses
    do_reset();
    done_delay = -2; noise_en = 1;
    for (int i = 0; i < 4000; i++) begin
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 2) != 0);
      data_a = {$urandom, $urandom};
      data_b = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    noise_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
